// File: rtl/imrom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imrom_arbiter
// Description : Round-robin arbiter/sequencer sharing a single-port
//               synchronous instruction ROM between the fetch (IF) port and
//               the constant-load (LD) port. One ROM read per cycle,
//               one-cycle ROM latency, 2-entry response FIFO per port.
// Revision    : 1.0 - initial release
// ============================================================================
module imrom_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // fetch request / response
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              if_rsp_err,
    // load request / response
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [ADDR_W-1:0] ld_req_addr,
    output logic              ld_rsp_valid,
    input  logic              ld_rsp_ready,
    output logic [DATA_W-1:0] ld_rsp_data,
    output logic              ld_rsp_err,
    // ROM
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    // Port identity; index 0 of every per-port vector is IF, index 1 is LD.
    typedef enum logic [0:0] {
        PORT_IF = 1'b0,
        PORT_LD = 1'b1
    } port_e;

    localparam int C_NPORT = 2;

    // ------------------------------------------------------------------
    // Per-port views of the request/response channels
    // ------------------------------------------------------------------
    logic [C_NPORT-1:0] w_req_valid;
    logic [C_NPORT-1:0] w_rsp_ready;
    logic [C_NPORT-1:0] w_pop;
    logic [C_NPORT-1:0] w_push;
    logic [C_NPORT-1:0] w_elig;
    logic [C_NPORT-1:0] w_cand;
    logic [C_NPORT-1:0] w_req_ready;
    logic [C_NPORT-1:0] w_grant;
    logic [C_NPORT-1:0] w_inflight;
    logic [C_NPORT-1:0] w_rsp_valid;
    logic [C_NPORT-1:0] w_rsp_err;
    logic [DATA_W-1:0]  w_rsp_data [C_NPORT];

    assign w_req_valid = {ld_req_valid, if_req_valid};
    assign w_rsp_ready = {ld_rsp_ready, if_rsp_ready};

    // ------------------------------------------------------------------
    // Arbitration and in-flight state
    // ------------------------------------------------------------------
    port_e             r_last_grant_q;
    port_e             w_last_grant_d;
    logic [ADDR_W-1:0] r_rom_addr_q;
    logic [ADDR_W-1:0] w_rom_addr_d;
    logic              r_inflight_v_q;
    logic              w_inflight_v_d;
    port_e             r_inflight_port_q;
    port_e             w_inflight_port_d;
    logic              r_inflight_err_q;
    logic              w_inflight_err_d;

    logic              w_if_wins_tie;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_cap_data;

    // The read issued last cycle lands in its owner's FIFO this edge.
    assign w_inflight[0] = r_inflight_v_q & (r_inflight_port_q == PORT_IF);
    assign w_inflight[1] = r_inflight_v_q & (r_inflight_port_q == PORT_LD);
    assign w_push        = w_inflight;

    // Misaligned reads still return a response, but with zeroed data.
    assign w_cap_data = r_inflight_err_q ? '0 : rom_data;

    // A requester competes only when its FIFO can absorb the response.
    assign w_cand        = w_req_valid & w_elig;
    assign w_if_wins_tie = (r_last_grant_q == PORT_LD);

    // Ready is held low during reset; otherwise a port is ready when it is
    // eligible and either wins the tie or has no competing candidate.
    assign w_req_ready[0] = ~rst & w_elig[0] & (~w_cand[1] |  w_if_wins_tie);
    assign w_req_ready[1] = ~rst & w_elig[1] & (~w_cand[0] | ~w_if_wins_tie);
    assign w_grant        = w_req_valid & w_req_ready;

    assign w_win_addr = w_grant[1] ? ld_req_addr : if_req_addr;

    // Next-state for grant history, ROM address hold and in-flight tracking.
    always_comb begin
        w_last_grant_d    = r_last_grant_q;
        w_rom_addr_d      = r_rom_addr_q;
        w_inflight_v_d    = 1'b0;
        w_inflight_port_d = r_inflight_port_q;
        w_inflight_err_d  = 1'b0;
        if (|w_grant) begin
            w_last_grant_d    = w_grant[1] ? PORT_LD : PORT_IF;
            w_rom_addr_d      = {2'b00, w_win_addr[ADDR_W-1:2]};
            w_inflight_v_d    = 1'b1;
            w_inflight_port_d = w_grant[1] ? PORT_LD : PORT_IF;
            w_inflight_err_d  = (w_win_addr[1:0] != 2'b00);
        end
    end

    // Arbiter registers; reset discards any pending ROM read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant_q    <= PORT_LD;
            r_rom_addr_q      <= '0;
            r_inflight_v_q    <= 1'b0;
            r_inflight_port_q <= PORT_IF;
            r_inflight_err_q  <= 1'b0;
        end else begin
            r_last_grant_q    <= w_last_grant_d;
            r_rom_addr_q      <= w_rom_addr_d;
            r_inflight_v_q    <= w_inflight_v_d;
            r_inflight_port_q <= w_inflight_port_d;
            r_inflight_err_q  <= w_inflight_err_d;
        end
    end

    // The winner's address goes straight to the ROM; otherwise hold.
    assign rom_addr = w_rom_addr_d;

    // ------------------------------------------------------------------
    // Per-port 2-entry response FIFOs
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < C_NPORT; gi++) begin : g_port
        logic [1:0]        r_cnt_q;
        logic [1:0]        w_cnt_d;
        logic              r_wr_ptr_q;
        logic              r_rd_ptr_q;
        logic [DATA_W-1:0] r_data_q [2];
        logic [1:0]        r_err_q;
        logic [2:0]        w_occ;

        assign w_rsp_valid[gi] = (r_cnt_q != 2'd0);
        assign w_pop[gi]       = w_rsp_valid[gi] & w_rsp_ready[gi];
        assign w_rsp_data[gi]  = r_data_q[r_rd_ptr_q];
        assign w_rsp_err[gi]   = r_err_q[r_rd_ptr_q];

        // Occupancy after this edge, before counting a new grant.
        assign w_occ      = {1'b0, r_cnt_q} - {2'b00, w_pop[gi]}
                          + {2'b00, w_inflight[gi]};
        assign w_elig[gi] = (w_occ < 3'd2);

        // FIFO count update; push and pop may coincide at any occupancy.
        always_comb begin
            w_cnt_d = r_cnt_q + {1'b0, w_push[gi]} - {1'b0, w_pop[gi]};
        end

        // FIFO storage and pointers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt_q     <= 2'd0;
                r_wr_ptr_q  <= 1'b0;
                r_rd_ptr_q  <= 1'b0;
                r_data_q[0] <= '0;
                r_data_q[1] <= '0;
                r_err_q     <= 2'b00;
            end else begin
                r_cnt_q <= w_cnt_d;
                if (w_push[gi]) begin
                    r_data_q[r_wr_ptr_q] <= w_cap_data;
                    r_err_q[r_wr_ptr_q]  <= r_inflight_err_q;
                    r_wr_ptr_q           <= ~r_wr_ptr_q;
                end
                if (w_pop[gi]) begin
                    r_rd_ptr_q <= ~r_rd_ptr_q;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign if_req_ready = w_req_ready[0];
    assign ld_req_ready = w_req_ready[1];
    assign if_rsp_valid = w_rsp_valid[0];
    assign ld_rsp_valid = w_rsp_valid[1];
    assign if_rsp_data  = w_rsp_data[0];
    assign ld_rsp_data  = w_rsp_data[1];
    assign if_rsp_err   = w_rsp_err[0];
    assign ld_rsp_err   = w_rsp_err[1];

endmodule
`default_nettype wire

// File: tb/tb_imrom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imrom_arbiter
// Description : Scoreboard bench for imrom_arbiter with a behavioural ROM,
//               directed scenarios and a randomized traffic phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imrom_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              if_req_valid, if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_rsp_valid, if_rsp_ready, if_rsp_err;
    logic [DATA_W-1:0] if_rsp_data;
    logic              ld_req_valid, ld_req_ready;
    logic [ADDR_W-1:0] ld_req_addr;
    logic              ld_rsp_valid, ld_rsp_ready, ld_rsp_err;
    logic [DATA_W-1:0] ld_rsp_data;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    imrom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_ready (if_rsp_ready),
        .if_rsp_data  (if_rsp_data),
        .if_rsp_err   (if_rsp_err),
        .ld_req_valid (ld_req_valid),
        .ld_req_ready (ld_req_ready),
        .ld_req_addr  (ld_req_addr),
        .ld_rsp_valid (ld_rsp_valid),
        .ld_rsp_ready (ld_rsp_ready),
        .ld_rsp_data  (ld_rsp_data),
        .ld_rsp_err   (ld_rsp_err),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port synchronous ROM (256 words).
    logic [DATA_W-1:0] rom_mem [256];
    always @(posedge clk) rom_data <= rom_mem[rom_addr[7:0]];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input bit ok,
                       input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: what a request to byte address a must return.
    function automatic logic [DATA_W:0] model_rsp(input logic [ADDR_W-1:0] a);
        if (a[1:0] != 2'b00) return {1'b1, {DATA_W{1'b0}}};
        return {1'b0, rom_mem[a[9:2]]};
    endfunction

    logic [DATA_W:0] q_if[$];
    logic [DATA_W:0] q_ld[$];
    int              out_if = 0, out_ld = 0;
    bit              stall_if = 0, stall_ld = 0;
    logic [DATA_W:0] held_if, held_ld;

    // Monitor: observes both channels between edges; transfers seen here
    // complete on the following rising edge.
    always @(negedge clk) begin
        logic [DATA_W:0] e;
        if (rst) begin
            q_if.delete(); q_ld.delete();
            out_if = 0; out_ld = 0;
            stall_if = 0; stall_ld = 0;
        end else begin
            if (stall_if)
                chk("if_rsp_hold", if_rsp_valid && {if_rsp_err, if_rsp_data} == held_if,
                    {31'b0, if_rsp_valid, if_rsp_err, if_rsp_data}, {31'b0, 1'b1, held_if});
            if (stall_ld)
                chk("ld_rsp_hold", ld_rsp_valid && {ld_rsp_err, ld_rsp_data} == held_ld,
                    {31'b0, ld_rsp_valid, ld_rsp_err, ld_rsp_data}, {31'b0, 1'b1, held_ld});
            stall_if = if_rsp_valid & ~if_rsp_ready;
            stall_ld = ld_rsp_valid & ~ld_rsp_ready;
            held_if  = {if_rsp_err, if_rsp_data};
            held_ld  = {ld_rsp_err, ld_rsp_data};

            if (if_rsp_valid && if_rsp_ready) begin
                if (q_if.size() == 0) chk("if_rsp_unexpected", 1'b0, 64'd1, 64'd0);
                else begin
                    e = q_if.pop_front();
                    chk("if_rsp", {if_rsp_err, if_rsp_data} == e, {if_rsp_err, if_rsp_data}, e);
                end
                out_if--;
            end
            if (ld_rsp_valid && ld_rsp_ready) begin
                if (q_ld.size() == 0) chk("ld_rsp_unexpected", 1'b0, 64'd1, 64'd0);
                else begin
                    e = q_ld.pop_front();
                    chk("ld_rsp", {ld_rsp_err, ld_rsp_data} == e, {ld_rsp_err, ld_rsp_data}, e);
                end
                out_ld--;
            end

            if (if_req_valid && if_req_ready && ld_req_valid && ld_req_ready)
                chk("single_grant", 1'b0, 64'd2, 64'd1);
            if (if_req_valid && if_req_ready) begin
                chk("if_rom_addr", rom_addr == (if_req_addr >> 2), rom_addr, if_req_addr >> 2);
                q_if.push_back(model_rsp(if_req_addr));
                out_if++;
                chk("if_no_overflow", out_if <= 2, out_if, 2);
            end
            if (ld_req_valid && ld_req_ready) begin
                chk("ld_rom_addr", rom_addr == (ld_req_addr >> 2), rom_addr, ld_req_addr >> 2);
                q_ld.push_back(model_rsp(ld_req_addr));
                out_ld++;
                chk("ld_no_overflow", out_ld <= 2, out_ld, 2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        if_req_valid = 0; ld_req_valid = 0;
        if_rsp_ready = 1; ld_rsp_ready = 1;
        repeat (n) tick();
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [ADDR_W-1:0] a;
        a = ADDR_W'($urandom_range(0, 255)) << 2;
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit gi, gl;
        int cnt_if, cnt_ld, wait_n;

        for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
        rom_mem[2] = 32'h1234_5678;

        // ---------------- reset state ----------------
        rst = 1;
        if_req_valid = 1; ld_req_valid = 1;
        if_req_addr = 32'h100; ld_req_addr = 32'h200;
        if_rsp_ready = 1; ld_rsp_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst_if_rsp_valid", if_rsp_valid == 0, if_rsp_valid, 0);
        chk("rst_ld_rsp_valid", ld_rsp_valid == 0, ld_rsp_valid, 0);
        chk("rst_if_data_err", {if_rsp_err, if_rsp_data} == 0, {if_rsp_err, if_rsp_data}, 0);
        chk("rst_ld_data_err", {ld_rsp_err, ld_rsp_data} == 0, {ld_rsp_err, ld_rsp_data}, 0);
        chk("rst_rom_addr", rom_addr == 0, rom_addr, 0);
        chk("rst_req_ready", {if_req_ready, ld_req_ready} == 2'b00, {if_req_ready, ld_req_ready}, 0);

        // ---------------- contention from reset ----------------
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            gi = if_req_valid & if_req_ready;
            gl = ld_req_valid & ld_req_ready;
            chk("contention_if_grant", gi == (i % 2 == 0), gi, (i % 2 == 0));
            chk("contention_ld_grant", gl == (i % 2 == 1), gl, (i % 2 == 1));
            tick();
            if (gi) if_req_addr += 4;
            if (gl) ld_req_addr += 4;
        end
        idle(6);

        // ---------------- single fetch ----------------
        if_req_valid = 1; if_req_addr = 32'h8;
        @(negedge clk);
        chk("single_ready", if_req_ready == 1, if_req_ready, 1);
        chk("single_rom_addr", rom_addr == 2, rom_addr, 2);
        tick();
        if_req_valid = 0;
        @(negedge clk);
        chk("single_not_early", if_rsp_valid == 0, if_rsp_valid, 0);
        tick();
        @(negedge clk);
        chk("single_valid", if_rsp_valid == 1, if_rsp_valid, 1);
        chk("single_data", {if_rsp_err, if_rsp_data} == {1'b0, 32'h1234_5678},
            {if_rsp_err, if_rsp_data}, {1'b0, 32'h1234_5678});
        idle(4);

        // ---------------- streaming fetch ----------------
        for (int i = 0; i < 16; i++) begin
            if_req_valid = 1; if_req_addr = 32'(i * 4);
            @(negedge clk);
            chk("stream_ready", if_req_ready == 1, if_req_ready, 1);
            tick();
        end
        idle(4);

        // ---------------- back-pressure ----------------
        if_rsp_ready = 0; ld_rsp_ready = 1;
        if_req_valid = 1; ld_req_valid = 1;
        if_req_addr = 32'h300; ld_req_addr = 32'h380;
        cnt_if = 0; cnt_ld = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            gi = if_req_valid & if_req_ready;
            gl = ld_req_valid & ld_req_ready;
            cnt_if += int'(gi); cnt_ld += int'(gl);
            tick();
            if (gi) if_req_addr += 4;
            if (gl) ld_req_addr = (ld_req_addr + 4) & 32'h3FC;
        end
        @(negedge clk);
        chk("bp_if_accepts", cnt_if == 2, cnt_if, 2);
        chk("bp_ld_accepts", cnt_ld == 8, cnt_ld, 8);
        chk("bp_if_blocked", if_req_ready == 0, if_req_ready, 0);
        tick();
        if_rsp_ready = 1;
        @(negedge clk);
        chk("bp_resume_same_cycle", if_req_ready == 1, if_req_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            gi = if_req_valid & if_req_ready;
            gl = ld_req_valid & ld_req_ready;
            tick();
            if (gi) if_req_addr += 4;
            if (gl) ld_req_addr = (ld_req_addr + 4) & 32'h3FC;
        end
        idle(6);

        // ---------------- misaligned load ----------------
        ld_req_valid = 1; ld_req_addr = 32'h6;
        @(negedge clk);
        chk("mis_ready", ld_req_ready == 1, ld_req_ready, 1);
        tick();
        ld_req_addr = 32'h8;
        @(negedge clk);
        tick();
        ld_req_valid = 0;
        wait_n = 0;
        @(negedge clk);
        while (!ld_rsp_valid && wait_n < 10) begin @(negedge clk); wait_n++; end
        chk("mis_err_zero", ld_rsp_valid && {ld_rsp_err, ld_rsp_data} == {1'b1, 32'h0},
            {ld_rsp_valid, ld_rsp_err, ld_rsp_data}, {2'b11, 32'h0});
        idle(6);

        // ---------------- randomized traffic ----------------
        if_req_valid = 0; ld_req_valid = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            gi = if_req_valid & if_req_ready;
            gl = ld_req_valid & ld_req_ready;
            tick();
            if (!if_req_valid || gi) begin
                if_req_valid = ($urandom_range(0, 3) != 0);
                if_req_addr  = rand_addr();
            end
            if (!ld_req_valid || gl) begin
                ld_req_valid = ($urandom_range(0, 2) != 0);
                ld_req_addr  = rand_addr();
            end
            if_rsp_ready = ($urandom_range(0, 2) != 0);
            ld_rsp_ready = ($urandom_range(0, 3) != 0);
        end
        idle(1);
        wait_n = 0;
        while ((q_if.size() != 0 || q_ld.size() != 0) && wait_n < 50) begin tick(); wait_n++; end
        chk("random_drain", q_if.size() == 0 && q_ld.size() == 0, q_if.size() + q_ld.size(), 0);

        // ---------------- reset mid-operation ----------------
        if_req_valid = 1; if_req_addr = 32'h10;
        @(negedge clk);
        chk("midrst_grant", if_req_ready == 1, if_req_ready, 1);
        @(posedge clk);
        #1 if_req_valid = 0;
        #1 rst = 1;
        @(posedge clk);
        #2 rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_rsp", {if_rsp_valid, ld_rsp_valid} == 2'b00,
                {if_rsp_valid, ld_rsp_valid}, 0);
            chk("midrst_rom_addr", rom_addr == 0, rom_addr, 0);
        end
        tick();
        if_req_valid = 1; ld_req_valid = 1;
        if_req_addr = 32'h20; ld_req_addr = 32'h40;
        @(negedge clk);
        chk("midrst_if_first", {if_req_ready, ld_req_ready} == 2'b10,
            {if_req_ready, ld_req_ready}, 2'b10);
        tick();
        if_req_valid = 0;
        @(negedge clk);
        tick();
        ld_req_valid = 0;
        idle(1);
        wait_n = 0;
        while ((q_if.size() != 0 || q_ld.size() != 0) && wait_n < 20) begin tick(); wait_n++; end
        chk("final_drain", q_if.size() == 0 && q_ld.size() == 0, q_if.size() + q_ld.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
